usb_in_ep_buf: RTL and testbench

Parametrised, multi-endpoint, double-buffered (ping-pong) IN packet buffer between the application and the USB protocol engine, in the `phy_ulpi_clk` domain. It succeeds the single-endpoint, single-bank `buf_in_*` path with these additions:
- `NUM_EP` independent endpoints, each with two banks, so the application can fill one packet while the engine transmits or retries the other.
- Per-endpoint flush.
- Overrun and underrun error pulses.

---
 rtl/usb_buf_pkg.sv | 23 ++
 rtl/usb_in_ep_buf_if.sv | 47 ++++
 rtl/usb_ep_bank_ctrl.sv | 88 ++++++++
 rtl/usb_in_ep_buf.sv | 89 ++++++++
 tb/tb_usb_in_ep_buf.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_buf_pkg.sv
// Shared types and defaults for the multi-endpoint
// ping-pong IN packet buffer.
package usb_buf_pkg;

    localparam int NUM_EP_DEF = 2;
    localparam int ADDR_W_DEF = 9;
    localparam int LEN_MAX_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } ep_state_e;

    // Length slots are sized for the widest supported bank.
    typedef struct packed {
        ep_state_e                 state;
        logic                      wr_bank;
        logic                      rd_bank;
        logic [1:0][LEN_MAX_W-1:0] len;
    } ep_ctrl_t;

endpackage

// File: rtl/usb_in_ep_buf_if.sv
// Application / protocol-engine side bundle of the
// IN endpoint buffer.
interface usb_in_ep_buf_if
    import usb_buf_pkg::*;
#(
    parameter int NUM_EP = NUM_EP_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = ADDR_W + 1,
    parameter int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
);
    logic [EP_W-1:0]   app_ep_sel;
    logic [ADDR_W-1:0] app_wr_addr;
    logic [7:0]        app_wr_data;
    logic              app_wren;
    logic              app_commit;
    logic [LEN_W-1:0]  app_commit_len;
    logic              app_commit_ack;
    logic [NUM_EP-1:0] app_ready;
    logic [EP_W-1:0]   pe_ep_sel;
    logic [ADDR_W-1:0] pe_rd_addr;
    logic [7:0]        pe_rd_data;
    logic [NUM_EP-1:0] pe_hasdata;
    logic [LEN_W-1:0]  pe_len;
    logic              pe_done;
    logic [NUM_EP-1:0] ep_flush;
    logic              err_overrun;
    logic              err_underrun;

    modport master (
        output app_ep_sel, app_wr_addr, app_wr_data,
        output app_wren, app_commit, app_commit_len,
        output pe_ep_sel, pe_rd_addr, pe_done, ep_flush,
        input  app_commit_ack, app_ready, pe_rd_data,
        input  pe_hasdata, pe_len,
        input  err_overrun, err_underrun
    );

    modport slave (
        input  app_ep_sel, app_wr_addr, app_wr_data,
        input  app_wren, app_commit, app_commit_len,
        input  pe_ep_sel, pe_rd_addr, pe_done, ep_flush,
        output app_commit_ack, app_ready, pe_rd_data,
        output pe_hasdata, pe_len,
        output err_overrun, err_underrun
    );

endinterface

// File: rtl/usb_ep_bank_ctrl.sv
// Per-endpoint bank FSM: fill/drain state, bank
// pointers, stored lengths and error pulses.
module usb_ep_bank_ctrl
    import usb_buf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             commit_i,
    input  logic             done_i,
    input  logic             flush_i,
    input  logic [LEN_W-1:0] len_i,
    output ep_ctrl_t         ctrl_o,
    output logic             ack_o,
    output logic             ovr_o,
    output logic             und_o,
    output logic             rdy_o,
    output logic             has_o
);
    localparam logic [LEN_W-1:0] BANK_LEN =
        LEN_W'(2 ** ADDR_W);

    ep_ctrl_t ctrl_q, ctrl_d;
    logic     ack_q, ack_d;
    logic     ovr_q, ovr_d;
    logic     und_q, und_d;
    logic     rdy_q, has_q;
    logic     is_full, is_empty, acc, dv, big;

    always_comb begin
        is_full  = (ctrl_q.state == FULL);
        is_empty = (ctrl_q.state == EMPTY);
        acc      = commit_i && !is_full;
        dv       = done_i && !is_empty;
        big      = (len_i > BANK_LEN);
        ctrl_d   = ctrl_q;
        if (acc) begin
            ctrl_d.wr_bank = ~ctrl_q.wr_bank;
            ctrl_d.len[ctrl_q.wr_bank] = big ?
                LEN_MAX_W'(BANK_LEN) : LEN_MAX_W'(len_i);
        end
        if (dv) begin
            ctrl_d.rd_bank = ~ctrl_q.rd_bank;
        end
        // Simultaneous commit and done cancel out.
        if (acc && !dv) begin
            ctrl_d.state = is_empty ? HALF : FULL;
        end else if (dv && !acc) begin
            ctrl_d.state = is_full ? HALF : EMPTY;
        end
        if (flush_i) begin
            ctrl_d.state   = EMPTY;
            ctrl_d.wr_bank = 1'b0;
            ctrl_d.rd_bank = 1'b0;
        end
        ack_d = acc && !flush_i;
        ovr_d = commit_i && (is_full || big) && !flush_i;
        und_d = done_i && is_empty && !flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            ack_q  <= 1'b0;
            ovr_q  <= 1'b0;
            und_q  <= 1'b0;
            rdy_q  <= 1'b0;
            has_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ack_q  <= ack_d;
            ovr_q  <= ovr_d;
            und_q  <= und_d;
            rdy_q  <= (ctrl_d.state != FULL);
            has_q  <= (ctrl_d.state != EMPTY);
        end
    end

    assign ctrl_o = ctrl_q;
    assign ack_o  = ack_q;
    assign ovr_o  = ovr_q;
    assign und_o  = und_q;
    assign rdy_o  = rdy_q;
    assign has_o  = has_q;

endmodule

// File: rtl/usb_in_ep_buf.sv
// Multi-endpoint double-buffered IN packet buffer:
// shared packet RAM, endpoint decode, output muxes.
module usb_in_ep_buf
    import usb_buf_pkg::*;
#(
    parameter int NUM_EP = NUM_EP_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = ADDR_W + 1,
    parameter int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic           phy_ulpi_clk,
    input  logic           reset,
    usb_in_ep_buf_if.slave bus
);
    localparam int AW    = EP_W + 1 + ADDR_W;
    localparam int DEPTH = NUM_EP * (2 ** (ADDR_W + 1));

    ep_ctrl_t             ctrl [NUM_EP];
    logic [NUM_EP-1:0]    ack, ovr, und, rdy, has;
    logic [7:0]           mem [DEPTH];
    logic [7:0]           rd_q;
    logic [LEN_W-1:0]     len_q;
    logic [AW-1:0]        wa, ra;
    logic [LEN_MAX_W-1:0] cur_len;
    logic                 unused_len_hi;
    logic                 wr_ok;

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        usb_ep_bank_ctrl #(
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_ctrl (
            .clk_i    (phy_ulpi_clk),
            .rst_i    (reset),
            .commit_i (bus.app_commit &&
                       bus.app_ep_sel == EP_W'(i)),
            .done_i   (bus.pe_done &&
                       bus.pe_ep_sel == EP_W'(i)),
            .flush_i  (bus.ep_flush[i]),
            .len_i    (bus.app_commit_len),
            .ctrl_o   (ctrl[i]),
            .ack_o    (ack[i]),
            .ovr_o    (ovr[i]),
            .und_o    (und[i]),
            .rdy_o    (rdy[i]),
            .has_o    (has[i])
        );
    end

    assign wa = {bus.app_ep_sel,
                 ctrl[bus.app_ep_sel].wr_bank,
                 bus.app_wr_addr};
    assign ra = {bus.pe_ep_sel,
                 ctrl[bus.pe_ep_sel].rd_bank,
                 bus.pe_rd_addr};
    assign cur_len = ctrl[bus.pe_ep_sel]
                     .len[ctrl[bus.pe_ep_sel].rd_bank];
    assign unused_len_hi = ^cur_len;

    // In FULL the write bank aliases the oldest packet.
    assign wr_ok = bus.app_wren &&
                   int'(bus.app_ep_sel) < NUM_EP &&
                   ctrl[bus.app_ep_sel].state != FULL;

    always_ff @(posedge phy_ulpi_clk) begin
        if (wr_ok) begin
            mem[wa] <= bus.app_wr_data;
        end
    end

    always_ff @(posedge phy_ulpi_clk) begin
        if (reset) begin
            rd_q  <= '0;
            len_q <= '0;
        end else begin
            rd_q  <= mem[ra];
            len_q <= cur_len[LEN_W-1:0];
        end
    end

    assign bus.app_commit_ack = |ack;
    assign bus.err_overrun    = |ovr;
    assign bus.err_underrun   = |und;
    assign bus.app_ready      = rdy;
    assign bus.pe_hasdata     = has;
    assign bus.pe_rd_data     = rd_q;
    assign bus.pe_len         = len_q;

endmodule

// File: tb/tb_usb_in_ep_buf.sv
// Scoreboard bench for usb_in_ep_buf: directed
// stimulus queues expectations, a monitor checks.
module tb_usb_in_ep_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_issue = 1'b0;
    logic rd_vld = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;

    int exp_ack_q[$];
    int exp_ovr_q[$];
    int exp_und_q[$];
    int exp_rd_q[$];

    usb_in_ep_buf_if #(.NUM_EP(2), .ADDR_W(9)) bus ();

    usb_in_ep_buf #(.NUM_EP(2), .ADDR_W(9)) dut (
        .phy_ulpi_clk (clk),
        .reset        (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_vld <= rd_issue;
    end

    function automatic void chk(string nm, int act,
                                int req);
        n_tot++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d",
                      nm, act, req);
    endfunction

    function automatic void miss(string nm, int act);
        n_tot++;
        $display("FAIL %s: unexpected %0d required none",
                 nm, act);
    endfunction

    function automatic int pat(int k, int i);
        case (k)
            0:       return i & 255;
            1:       return (8'hA0 + i) & 255;
            2:       return (i ^ 8'h5A) & 255;
            3:       return (8'hC0 + i) & 255;
            default: return (8'h70 + i) & 255;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.app_commit_ack === 1'b1) begin
            if (exp_ack_q.size() == 0) miss("ack", cyc);
            else chk("ack_cyc", cyc, exp_ack_q.pop_front());
        end
        if (bus.err_overrun === 1'b1) begin
            if (exp_ovr_q.size() == 0) miss("ovr", cyc);
            else chk("ovr_cyc", cyc, exp_ovr_q.pop_front());
        end
        if (bus.err_underrun === 1'b1) begin
            if (exp_und_q.size() == 0) miss("und", cyc);
            else chk("und_cyc", cyc, exp_und_q.pop_front());
        end
        if (rd_vld) begin
            if (exp_rd_q.size() == 0)
                miss("rd_data", int'(bus.pe_rd_data));
            else
                chk("rd_data", int'(bus.pe_rd_data),
                    exp_rd_q.pop_front());
        end
    end

    task automatic clr();
        bus.app_wren   = 1'b0;
        bus.app_commit = 1'b0;
        bus.pe_done    = 1'b0;
        bus.ep_flush   = 2'b00;
        rd_issue       = 1'b0;
    endtask

    task automatic cyc_wait(int n);
        repeat (n) begin
            @(negedge clk);
            clr();
        end
    endtask

    task automatic wr(int ep, int a, int d);
        @(negedge clk);
        clr();
        bus.app_ep_sel  = 1'(ep);
        bus.app_wr_addr = 9'(a);
        bus.app_wr_data = 8'(d);
        bus.app_wren    = 1'b1;
    endtask

    task automatic wr_pkt(int ep, int n, int k);
        for (int i = 0; i < n; i++) wr(ep, i, pat(k, i));
    endtask

    task automatic commit(int ep, int len, bit a, bit o);
        @(negedge clk);
        clr();
        bus.app_ep_sel     = 1'(ep);
        bus.app_commit_len = 10'(len);
        bus.app_commit     = 1'b1;
        if (a) exp_ack_q.push_back(cyc + 1);
        if (o) exp_ovr_q.push_back(cyc + 1);
    endtask

    task automatic done(int ep, bit u);
        @(negedge clk);
        clr();
        bus.pe_ep_sel = 1'(ep);
        bus.pe_done   = 1'b1;
        if (u) exp_und_q.push_back(cyc + 1);
    endtask

    task automatic commit_done(int ep, int len);
        @(negedge clk);
        clr();
        bus.app_ep_sel     = 1'(ep);
        bus.app_commit_len = 10'(len);
        bus.app_commit     = 1'b1;
        bus.pe_ep_sel      = 1'(ep);
        bus.pe_done        = 1'b1;
        exp_ack_q.push_back(cyc + 1);
    endtask

    task automatic rd_pkt(int ep, int n, int k);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clr();
            bus.pe_ep_sel  = 1'(ep);
            bus.pe_rd_addr = 9'(i);
            rd_issue       = 1'b1;
            exp_rd_q.push_back(pat(k, i));
        end
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_ready"}, int'(bus.app_ready), 0);
        chk({tag, "_hasdata"}, int'(bus.pe_hasdata), 0);
        chk({tag, "_ack"}, int'(bus.app_commit_ack), 0);
        chk({tag, "_ovr"}, int'(bus.err_overrun), 0);
        chk({tag, "_und"}, int'(bus.err_underrun), 0);
        chk({tag, "_rd"}, int'(bus.pe_rd_data), 0);
        chk({tag, "_len"}, int'(bus.pe_len), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.app_ep_sel     = '0;
        bus.app_wr_addr    = '0;
        bus.app_wr_data    = '0;
        bus.app_commit_len = '0;
        bus.pe_ep_sel      = '0;
        bus.pe_rd_addr     = '0;
        clr();
        cyc_wait(3);
        chk_reset_outs("rst");
        rst = 1'b0;
        cyc_wait(1);
        chk("post_rst_ready", int'(bus.app_ready), 3);
        chk("post_rst_hasdata", int'(bus.pe_hasdata), 0);

        wr_pkt(0, 64, 0);
        commit(0, 64, 1'b1, 1'b0);
        cyc_wait(1);
        chk("ep0_hasdata", int'(bus.pe_hasdata), 1);
        cyc_wait(1);
        chk("ep0_len64", int'(bus.pe_len), 64);
        rd_pkt(0, 64, 0);
        done(0, 1'b0);
        cyc_wait(1);
        chk("ep0_drained", int'(bus.pe_hasdata), 0);
        chk("ep0_ready", int'(bus.app_ready), 3);

        wr_pkt(1, 8, 1);
        commit(1, 8, 1'b1, 1'b0);
        wr_pkt(1, 512, 2);
        commit(1, 512, 1'b1, 1'b0);
        cyc_wait(1);
        chk("ep1_full_ready", int'(bus.app_ready), 1);
        chk("ep1_full_has", int'(bus.pe_hasdata), 2);
        commit(1, 8, 1'b0, 1'b1);
        wr(1, 0, 8'hFF);
        cyc_wait(1);
        chk("ep1_still_full", int'(bus.app_ready), 1);
        bus.pe_ep_sel = 1'b1;
        cyc_wait(2);
        chk("ep1_len8", int'(bus.pe_len), 8);
        rd_pkt(1, 8, 1);
        done(1, 1'b0);
        cyc_wait(1);
        chk("ep1_ready_back", int'(bus.app_ready), 3);
        cyc_wait(1);
        chk("ep1_len512", int'(bus.pe_len), 512);
        rd_pkt(1, 512, 2);
        done(1, 1'b0);
        cyc_wait(1);
        chk("ep1_drained", int'(bus.pe_hasdata), 0);

        wr_pkt(0, 16, 3);
        commit(0, 16, 1'b1, 1'b0);
        wr_pkt(0, 4, 4);
        commit_done(0, 4);
        cyc_wait(1);
        chk("cd_ready", int'(bus.app_ready), 3);
        chk("cd_hasdata", int'(bus.pe_hasdata), 1);
        bus.pe_ep_sel = 1'b0;
        cyc_wait(1);
        chk("cd_len4", int'(bus.pe_len), 4);
        rd_pkt(0, 4, 4);
        done(0, 1'b0);
        cyc_wait(1);
        chk("cd_half_then_empty", int'(bus.pe_hasdata), 0);

        commit(0, 600, 1'b1, 1'b1);
        cyc_wait(2);
        chk("clamp_len", int'(bus.pe_len), 512);
        chk("clamp_has", int'(bus.pe_hasdata), 1);
        done(0, 1'b0);
        done(0, 1'b1);
        cyc_wait(1);
        chk("und_hasdata", int'(bus.pe_hasdata), 0);
        chk("und_ready", int'(bus.app_ready), 3);

        commit(0, 10, 1'b1, 1'b0);
        commit(0, 20, 1'b1, 1'b0);
        commit(1, 30, 1'b1, 1'b0);
        cyc_wait(1);
        chk("pre_flush_ready", int'(bus.app_ready), 2);
        chk("pre_flush_has", int'(bus.pe_hasdata), 3);
        @(negedge clk);
        clr();
        bus.ep_flush       = 2'b01;
        bus.app_ep_sel     = 1'b0;
        bus.app_commit_len = 10'd5;
        bus.app_commit     = 1'b1;
        cyc_wait(1);
        chk("flush_ready", int'(bus.app_ready), 3);
        chk("flush_has", int'(bus.pe_hasdata), 2);
        bus.pe_ep_sel = 1'b1;
        cyc_wait(2);
        chk("flush_ep1_len", int'(bus.pe_len), 30);

        @(negedge clk);
        clr();
        bus.app_ep_sel  = 1'b1;
        bus.app_wr_addr = 9'd3;
        bus.app_wren    = 1'b1;
        rst             = 1'b1;
        cyc_wait(1);
        chk_reset_outs("midrst");
        rst = 1'b0;
        cyc_wait(1);
        chk("midrst_ready", int'(bus.app_ready), 3);
        chk("midrst_has", int'(bus.pe_hasdata), 0);

        cyc_wait(3);
        chk("ack_left", exp_ack_q.size(), 0);
        chk("ovr_left", exp_ovr_q.size(), 0);
        chk("und_left", exp_und_q.size(), 0);
        chk("rd_left", exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
